// File: rtl/exu_alu_arb.sv
// Purpose : shares one combinational EXU ALU between port 0 (EXU issue) and port 1 (LSU aux) with
//           round-robin grant and a one-entry registered result buffer per port.
// Latency : a request accepted in cycle T has its result valid in cycle T+1; 1 op/cycle total.
// Backpr. : a port is eligible only if its buffer is empty or draining this cycle, so a stalled
//           consumer blocks only its own port and buffered results are never overwritten.
//
// Ports   : clk, rst (synchronous, active high)
//           req{0,1}_valid/_ready/_a/_b/_funct : request channels (ready = grant, combinational)
//           rsp{0,1}_valid/_ready/_result      : registered response buffers
//           alu_a/alu_b/alu_funct -> ALU, alu_result <- ALU (combinational)
// Config  : define EXU_ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins whenever eligible);
//           last_grant is still tracked in that build but does not affect arbitration.

module exu_alu_arb #(
  parameter int                  DATA_W     = 32,
  parameter int                  FUNCT_W    = 4,
  parameter logic [FUNCT_W-1:0]  IDLE_FUNCT = '0
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [FUNCT_W-1:0] req0_funct,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [DATA_W-1:0]  rsp0_result,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [FUNCT_W-1:0] req1_funct,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp1_result,

  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [FUNCT_W-1:0] alu_funct,
  input  logic [DATA_W-1:0]  alu_result
);

  // 0 = port 0 was granted most recently, 1 = port 1.
  logic last_grant;
  logic elig0, elig1;
  logic grant0, grant1;

  // A buffer being drained this cycle can take a new result at the same edge.
  assign elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
  assign elig1 = req1_valid && (!rsp1_valid || rsp1_ready);

  // Grants are suppressed during reset so nothing accepted in a reset cycle
  // produces a response afterwards.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
`ifdef EXU_ALU_ARB_FIXED_PRIO_EN
      grant0 = elig0;
      grant1 = elig1 && !elig0;
`else
      // On a tie the port that did not win last time goes first.
      grant0 = elig0 && (!elig1 || last_grant);
      grant1 = elig1 && (!elig0 || !last_grant);
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Winner's operands go to the ALU; a quiet idle pattern otherwise.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_funct = IDLE_FUNCT;
    if (grant0) begin
      alu_a     = req0_a;
      alu_b     = req0_b;
      alu_funct = req0_funct;
    end else if (grant1) begin
      alu_a     = req1_a;
      alu_b     = req1_b;
      alu_funct = req1_funct;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      last_grant  <= 1'b1;
    end else begin
      // A new grant takes priority over draining: refill keeps valid high.
      if (grant0) begin
        rsp0_result <= alu_result;
        rsp0_valid  <= 1'b1;
      end else if (rsp0_valid && rsp0_ready) begin
        rsp0_valid  <= 1'b0;
      end

      if (grant1) begin
        rsp1_result <= alu_result;
        rsp1_valid  <= 1'b1;
      end else if (rsp1_valid && rsp1_ready) begin
        rsp1_valid  <= 1'b0;
      end

      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exu_alu_arb.sv
// Self-checking bench for exu_alu_arb: directed scenarios plus a randomized run
// against a queue-based model of the two response buffers.

module tb_exu_alu_arb;

  localparam int DW = 32;
  localparam int FW = 4;
  localparam logic [FW-1:0] F_IDLE = 4'd0;
  localparam logic [FW-1:0] F_ADD  = 4'd1;
  localparam logic [FW-1:0] F_SUB  = 4'd2;
  localparam logic [FW-1:0] F_AND  = 4'd3;
  localparam logic [FW-1:0] F_OR   = 4'd4;
  localparam logic [FW-1:0] F_XOR  = 4'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [DW-1:0] req0_a, req0_b, rsp0_result;
  logic [FW-1:0] req0_funct;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] req1_a, req1_b, rsp1_result;
  logic [FW-1:0] req1_funct;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [FW-1:0] alu_funct;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_alu(input logic [FW-1:0] f,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (f)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_XOR:   return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Behavioural ALU standing in for the shared EXU ALU.
  assign alu_result = ref_alu(alu_funct, alu_a, alu_b);

  exu_alu_arb #(.DATA_W(DW), .FUNCT_W(FW), .IDLE_FUNCT(F_IDLE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_funct(req0_funct), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_funct(req1_funct), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct), .alu_result(alu_result)
  );

  task automatic drive0(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [FW-1:0] f);
    req0_valid = v; req0_a = a; req0_b = b; req0_funct = f;
  endtask

  task automatic drive1(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [FW-1:0] f);
    req1_valid = v; req1_a = a; req1_b = b; req1_funct = f;
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    drive0(1'b0, '0, '0, F_IDLE);
    drive1(1'b0, '0, '0, F_IDLE);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive0(1'b1, 32'd11, 32'd22, F_ADD);
    drive1(1'b1, 32'd33, 32'd44, F_SUB);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
      checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
      checks++; if (rsp0_result !== '0 || rsp1_result !== '0) begin failures++; $display("FAIL reset_rsp_result: got %0h/%0h want 0/0", rsp0_result, rsp1_result); end
      checks++; if (alu_funct !== F_IDLE) begin failures++; $display("FAIL reset_alu_funct: got %0h want %0h", alu_funct, F_IDLE); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive0(1'b0, '0, '0, F_IDLE);
    drive1(1'b0, '0, '0, F_IDLE);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    // Requests offered during reset must not yield a response.
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin failures++; $display("FAIL reset_no_rsp: got %b%b want 00", rsp0_valid, rsp1_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_reset();
    drive0(1'b1, 32'd3, 32'd4, F_ADD);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b want 1", req0_ready); end
    checks++; if (alu_a !== 32'd3 || alu_b !== 32'd4 || alu_funct !== F_ADD) begin failures++; $display("FAIL single_alu_drive: got %0h %0h %0h want 3 4 %0h", alu_a, alu_b, alu_funct, F_ADD); end
    @(posedge clk); #1;
    drive0(1'b0, '0, '0, F_IDLE);
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid: got %b want 1", rsp0_valid); end
    checks++; if (rsp0_result !== 32'd7) begin failures++; $display("FAIL single_rsp_result: got %0d want 7", rsp0_result); end
    checks++; if (alu_a !== '0 || alu_funct !== F_IDLE) begin failures++; $display("FAIL single_idle_alu: got %0h %0h want 0 %0h", alu_a, alu_funct, F_IDLE); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL single_drain: got %b want 0", rsp0_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    int prev;
    do_reset();
    drive0(1'b1, 32'd5, 32'd1, F_ADD);
    drive1(1'b1, 32'd9, 32'd2, F_SUB);
    prev = -1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (prev == 0) begin
        checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd6) begin failures++; $display("FAIL tie_rsp0 cycle %0d: got v=%b r=%0d want v=1 r=6", i, rsp0_valid, rsp0_result); end
      end else if (prev == 1) begin
        checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd7) begin failures++; $display("FAIL tie_rsp1 cycle %0d: got v=%b r=%0d want v=1 r=7", i, rsp1_valid, rsp1_result); end
      end
      if (i < 4) begin
        checks++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin failures++; $display("FAIL tie_grant cycle %0d: got %b%b want %b%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1)); end
        prev = i % 2;
      end
      @(posedge clk); #1;
      if (i == 3) begin
        drive0(1'b0, '0, '0, F_IDLE);
        drive1(1'b0, '0, '0, F_IDLE);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp0_ready = 1'b0;
    drive0(1'b1, 32'd10, 32'd20, F_ADD);
    @(posedge clk); #1;
    drive0(1'b1, 32'd1, 32'd1, F_ADD);
    drive1(1'b1, 32'd100, 32'd3, F_XOR);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin failures++; $display("FAIL bp_grant cycle %0d: got %b%b want 01", i, req0_ready, req1_ready); end
      checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd30) begin failures++; $display("FAIL bp_hold cycle %0d: got v=%b r=%0d want v=1 r=30", i, rsp0_valid, rsp0_result); end
      if (i > 0) begin
        checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd103) begin failures++; $display("FAIL bp_rsp1 cycle %0d: got v=%b r=%0d want v=1 r=103", i, rsp1_valid, rsp1_result); end
      end
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL bp_resume: got %b%b want 10", req0_ready, req1_ready); end
    @(posedge clk); #1;
    drive0(1'b0, '0, '0, F_IDLE);
    drive1(1'b0, '0, '0, F_IDLE);
    @(negedge clk);
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd2) begin failures++; $display("FAIL bp_resume_rsp: got v=%b r=%0d want v=1 r=2", rsp0_valid, rsp0_result); end
    @(posedge clk); #1;
  endtask

  task automatic test_drain_refill();
    do_reset();
    drive1(1'b1, 32'd9, 32'd2, F_SUB);
    @(posedge clk); #1;
    drive1(1'b1, 32'd8, 32'd12, F_AND);
    @(negedge clk);
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd7) begin failures++; $display("FAIL refill_first: got v=%b r=%0d want v=1 r=7", rsp1_valid, rsp1_result); end
    checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL refill_grant: got %b want 1", req1_ready); end
    @(posedge clk); #1;
    drive1(1'b0, '0, '0, F_IDLE);
    @(negedge clk);
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd8) begin failures++; $display("FAIL refill_second: got v=%b r=%0d want v=1 r=8", rsp1_valid, rsp1_result); end
    @(posedge clk); #1;
  endtask

  task automatic test_prio();
    int n0, n1, exp0, exp1;
    do_reset();
    n0 = 0; n1 = 0;
    drive0(1'b1, 32'd1, 32'd2, F_OR);
    drive1(1'b1, 32'd4, 32'd8, F_OR);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (req0_ready === 1'b1) n0++;
      if (req1_ready === 1'b1) n1++;
      @(posedge clk); #1;
    end
    drive0(1'b0, '0, '0, F_IDLE);
    drive1(1'b0, '0, '0, F_IDLE);
`ifdef EXU_ALU_ARB_FIXED_PRIO_EN
    exp0 = 4; exp1 = 0;
`else
    exp0 = 2; exp1 = 2;
`endif
    checks++; if (n0 != exp0) begin failures++; $display("FAIL prio_port0_grants: got %0d want %0d", n0, exp0); end
    checks++; if (n1 != exp1) begin failures++; $display("FAIL prio_port1_grants: got %0d want %0d", n1, exp1); end
    @(posedge clk); #1;
  endtask

  // Model: each port's response buffer is a queue of results still owed to
  // its consumer; arbitration picks among ports that can accept a result now.
  task automatic test_random();
    logic [DW-1:0] q0[$], q1[$];
    logic          pend0, pend1, e0, e1, g0, g1;
    int            last;
    do_reset();
    last = 1;
    pend0 = 1'b0; pend1 = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pend0 && $urandom_range(0, 9) < 6) begin
        pend0 = 1'b1;
        drive0(1'b1, $urandom, $urandom, 4'($urandom_range(0, 5)));
      end
      if (!pend1 && $urandom_range(0, 9) < 6) begin
        pend1 = 1'b1;
        drive1(1'b1, $urandom, $urandom, 4'($urandom_range(0, 5)));
      end
      req0_valid = pend0;
      req1_valid = pend1;
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      e0 = pend0 && (q0.size() == 0 || rsp0_ready);
      e1 = pend1 && (q1.size() == 0 || rsp1_ready);
`ifdef EXU_ALU_ARB_FIXED_PRIO_EN
      g0 = e0;
      g1 = e1 && !e0;
`else
      g0 = e0 && (!e1 || last == 1);
      g1 = e1 && (!e0 || last == 0);
`endif
      checks++; if (req0_ready !== g0 || req1_ready !== g1) begin failures++; $display("FAIL rand_grant cyc %0d: got %b%b want %b%b", cyc, req0_ready, req1_ready, g0, g1); end
      checks++; if (rsp0_valid !== (q0.size() != 0) || (q0.size() != 0 && rsp0_result !== q0[0])) begin failures++; $display("FAIL rand_rsp0 cyc %0d: got v=%b r=%0h want v=%b r=%0h", cyc, rsp0_valid, rsp0_result, q0.size() != 0, (q0.size() != 0) ? q0[0] : '0); end
      checks++; if (rsp1_valid !== (q1.size() != 0) || (q1.size() != 0 && rsp1_result !== q1[0])) begin failures++; $display("FAIL rand_rsp1 cyc %0d: got v=%b r=%0h want v=%b r=%0h", cyc, rsp1_valid, rsp1_result, q1.size() != 0, (q1.size() != 0) ? q1[0] : '0); end
      if (!g0 && !g1) begin
        checks++; if (alu_a !== '0 || alu_b !== '0 || alu_funct !== F_IDLE) begin failures++; $display("FAIL rand_idle_alu cyc %0d: got %0h %0h %0h want 0 0 %0h", cyc, alu_a, alu_b, alu_funct, F_IDLE); end
      end
      // Apply the upcoming edge to the model.
      if (q0.size() != 0 && rsp0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && rsp1_ready) void'(q1.pop_front());
      if (g0) begin q0.push_back(ref_alu(req0_funct, req0_a, req0_b)); pend0 = 1'b0; last = 0; end
      if (g1) begin q1.push_back(ref_alu(req1_funct, req1_a, req1_b)); pend1 = 1'b0; last = 1; end
      @(posedge clk); #1;
      if (!pend0) req0_valid = 1'b0;
      if (!pend1) req1_valid = 1'b0;
    end
    drive0(1'b0, '0, '0, F_IDLE);
    drive1(1'b0, '0, '0, F_IDLE);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_drain_refill();
    test_prio();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
